// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART TX message arbiter.
//   state_t     : arbiter FSM state encoding (ST_IDLE / ST_XFER)
//   clog2_min1  : index width for NREQ requesters (never less than 1 bit)
package uart_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester / UART-FIFO bundle for uart_tx_arbiter.
//   master : requesters + FIFO side (drives bytes and tx_full, sees ready/grant)
//   slave  : the arbiter
// Requester i owns bits [i*DBIT +: DBIT] of req_data.
interface uart_tx_arbiter_if #(
    parameter int NREQ = 2,
    parameter int DBIT = 8
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*DBIT-1:0] req_data;
    logic [NREQ-1:0]      req_last;
    logic [NREQ-1:0]      req_ready;
    logic                 tx_full;
    logic                 wr_uart;
    logic [DBIT-1:0]      data_in;
    logic [NREQ-1:0]      grant;
    logic                 busy;
    logic                 abort;

    modport master (
        output req_valid, req_data, req_last, tx_full,
        input  req_ready, wr_uart, data_in, grant, busy, abort
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_full,
        output req_ready, wr_uart, data_in, grant, busy, abort
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector.
//   i_req : request vector
//   i_ptr : index with highest priority this round
//   o_gnt : one-hot winner, o_idx : its binary index, o_any : some request present
// The search wraps with an explicit subtract of NREQ so non-power-of-two
// NREQ never visits a nonexistent index.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IW   = clog2_min1(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [IW-1:0]   o_idx,
    output logic            o_any
);
    localparam int SW = IW + 1;

    logic [SW-1:0] w_sum;
    logic [IW-1:0] w_cand;

    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        w_sum  = '0;
        w_cand = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, i_ptr} + SW'(k);
            if (w_sum >= SW'(NREQ)) w_sum = w_sum - SW'(NREQ);
            w_cand = w_sum[IW-1:0];
            if (!o_any && i_req[w_cand]) begin
                o_any         = 1'b1;
                o_gnt[w_cand] = 1'b1;
                o_idx         = w_cand;
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin message arbiter in front of a UART TX FIFO write port.
//   i_clk   : clock, rising edge
//   i_reset : synchronous active-low reset
//   bus     : requester bytes/last/valid/ready, tx_full, wr_uart/data_in,
//             grant (registered one-hot), busy, abort (watchdog pulse)
// The grant is held for a whole message (through the byte flagged last);
// a watchdog revokes it after TMO consecutive cycles without a handshake.
//
// state   | meaning
// ST_IDLE | no owner; pick next requester at/after rr_ptr
// ST_XFER | owner r_gidx forwards bytes to the FIFO
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int DBIT  = 8,
    parameter int TMO   = 1024,
    parameter int TMO_W = 11
) (
    input logic               i_clk,
    input logic               i_reset,
    uart_tx_arbiter_if.slave  bus
);
    localparam int IW = clog2_min1(NREQ);

    state_t          r_state, w_state_nxt;
    logic [IW-1:0]   r_rr_ptr, w_rr_ptr_nxt;
    logic [IW-1:0]   r_gidx, w_gidx_nxt;
    logic [NREQ-1:0] r_grant, w_grant_nxt;
    logic [TMO_W-1:0] r_tmo_cnt, w_tmo_cnt_nxt;

    logic [NREQ-1:0] w_pick_gnt;
    logic [IW-1:0]   w_pick_idx;
    logic            w_pick_any;
    logic            w_xfer;
    logic            w_accept;
    logic            w_hs;
    logic            w_tmo_hit;
    logic [IW-1:0]   w_ptr_after;
    logic [DBIT-1:0] w_data;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .i_req (bus.req_valid),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    assign w_xfer = (r_state == ST_XFER);
    // Acceptance is suppressed while reset is low so the reset cycle never writes.
    assign w_accept    = w_xfer & i_reset & ~bus.tx_full;
    assign w_hs        = w_accept & bus.req_valid[r_gidx];
    assign w_tmo_hit   = (r_tmo_cnt == TMO_W'(TMO - 1));
    assign w_ptr_after = (r_gidx == IW'(NREQ - 1)) ? '0 : r_gidx + IW'(1);

    always_comb begin
        w_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_gidx == IW'(i)) w_data = bus.req_data[i*DBIT +: DBIT];
        end
    end

    assign bus.req_ready = w_accept ? r_grant : '0;
    assign bus.wr_uart   = w_hs;
    assign bus.data_in   = w_xfer ? w_data : '0;
    assign bus.grant     = r_grant;
    assign bus.busy      = w_xfer;
    assign bus.abort     = w_xfer & ~w_hs & w_tmo_hit;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state   <= ST_IDLE;
            r_rr_ptr  <= '0;
            r_gidx    <= '0;
            r_grant   <= '0;
            r_tmo_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_rr_ptr  <= w_rr_ptr_nxt;
            r_gidx    <= w_gidx_nxt;
            r_grant   <= w_grant_nxt;
            r_tmo_cnt <= w_tmo_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_rr_ptr_nxt  = r_rr_ptr;
        w_gidx_nxt    = r_gidx;
        w_grant_nxt   = r_grant;
        w_tmo_cnt_nxt = r_tmo_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_any) begin
                    w_state_nxt   = ST_XFER;
                    w_grant_nxt   = w_pick_gnt;
                    w_gidx_nxt    = w_pick_idx;
                    w_tmo_cnt_nxt = '0;
                end
            end
            ST_XFER: begin
                if (w_hs) begin
                    w_tmo_cnt_nxt = '0;
                    if (bus.req_last[r_gidx]) begin
                        w_state_nxt  = ST_IDLE;
                        w_grant_nxt  = '0;
                        w_rr_ptr_nxt = w_ptr_after;
                    end
                end else if (w_tmo_hit) begin
                    // Stalled owner: drop the rest of its message, move priority on.
                    w_state_nxt   = ST_IDLE;
                    w_grant_nxt   = '0;
                    w_rr_ptr_nxt  = w_ptr_after;
                    w_tmo_cnt_nxt = '0;
                end else begin
                    w_tmo_cnt_nxt = r_tmo_cnt + TMO_W'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
    localparam int TMO = 8;

    logic clk;
    logic rst_n;

    // index 0 drives the NREQ=2 arbiter, index 1 the NREQ=3 arbiter
    logic [2:0] val [2];
    logic [2:0] lst [2];
    logic [7:0] dat [2][3];
    logic       full [2];

    int vectors;
    int errors;

    // reference model: owner (-1 = none), round-robin pointer, stalled cycles
    int m_own [2];
    int m_ptr [2];
    int m_stall [2];
    bit m_hs [2];

    int seq [2][3];
    logic [7:0] wlog [$];

    uart_tx_arbiter_if #(.NREQ(2), .DBIT(8)) if2 ();
    uart_tx_arbiter_if #(.NREQ(3), .DBIT(8)) if3 ();

    assign if2.req_valid = val[0][1:0];
    assign if2.req_last  = lst[0][1:0];
    assign if2.req_data  = {dat[0][1], dat[0][0]};
    assign if2.tx_full   = full[0];
    assign if3.req_valid = val[1];
    assign if3.req_last  = lst[1];
    assign if3.req_data  = {dat[1][2], dat[1][1], dat[1][0]};
    assign if3.tx_full   = full[1];

    uart_tx_arbiter #(.NREQ(2), .DBIT(8), .TMO(TMO), .TMO_W(4)) dut2 (
        .i_clk(clk), .i_reset(rst_n), .bus(if2.slave));
    uart_tx_arbiter #(.NREQ(3), .DBIT(8), .TMO(TMO), .TMO_W(4)) dut3 (
        .i_clk(clk), .i_reset(rst_n), .bus(if3.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic reset_model();
        for (int d = 0; d < 2; d++) begin
            m_own[d] = -1;
            m_ptr[d] = 0;
            m_stall[d] = 0;
            m_hs[d] = 1'b0;
        end
    endtask

    task automatic check_model(input int d);
        logic [2:0] eg, er, ag, ar;
        logic       eb, ea, ab, aa, aw;
        logic [7:0] ed, ad;
        bit         hs;
        eb = (m_own[d] >= 0);
        eg = 3'b000; er = 3'b000; ed = 8'h00; hs = 1'b0;
        if (eb) begin
            eg = 3'(1 << m_own[d]);
            ed = dat[d][m_own[d]];
            hs = val[d][m_own[d]] && !full[d] && rst_n;
            if (!full[d] && rst_n) er = eg;
        end
        ea = eb && !hs && (m_stall[d] == TMO - 1);
        m_hs[d] = hs;
        if (d == 0) begin
            ag = {1'b0, if2.grant}; ab = if2.busy; aa = if2.abort;
            ar = {1'b0, if2.req_ready}; aw = if2.wr_uart; ad = if2.data_in;
        end else begin
            ag = if3.grant; ab = if3.busy; aa = if3.abort;
            ar = if3.req_ready; aw = if3.wr_uart; ad = if3.data_in;
        end
        vectors++;
        if ({ag, ab, aa, ar, aw, ad} !== {eg, eb, ea, er, hs, ed}) begin
            errors++;
            $display("FAIL model_dut%0d t=%0t got g=%b b=%b a=%b r=%b w=%b d=%h expected g=%b b=%b a=%b r=%b w=%b d=%h",
                     d, $time, ag, ab, aa, ar, aw, ad, eg, eb, ea, er, hs, ed);
        end
    endtask

    task automatic update_model(input int d);
        int n;
        n = (d == 0) ? 2 : 3;
        if (!rst_n) begin
            m_own[d] = -1; m_ptr[d] = 0; m_stall[d] = 0;
        end else if (m_own[d] < 0) begin
            for (int k = 0; k < n; k++) begin
                if (m_own[d] < 0 && val[d][(m_ptr[d] + k) % n]) begin
                    m_own[d] = (m_ptr[d] + k) % n;
                    m_stall[d] = 0;
                end
            end
        end else if (m_hs[d]) begin
            m_stall[d] = 0;
            if (lst[d][m_own[d]]) begin
                m_ptr[d] = (m_own[d] + 1) % n;
                m_own[d] = -1;
            end
        end else if (m_stall[d] == TMO - 1) begin
            m_ptr[d] = (m_own[d] + 1) % n;
            m_own[d] = -1;
            m_stall[d] = 0;
        end else begin
            m_stall[d]++;
        end
    endtask

    task automatic half_neg();
        @(negedge clk);
        check_model(0);
        check_model(1);
    endtask

    task automatic half_pos();
        @(posedge clk);
        update_model(0);
        update_model(1);
        #1;
    endtask

    task automatic step();
        half_neg();
        half_pos();
    endtask

    task automatic clear_inputs();
        for (int d = 0; d < 2; d++) begin
            val[d] = 3'b000; lst[d] = 3'b000; full[d] = 1'b0;
            for (int i = 0; i < 3; i++) begin
                dat[d][i] = 8'h00;
                seq[d][i] = 0;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        @(posedge clk);
        reset_model();
        #1;
        step();
        rst_n = 1'b1;
    endtask

    // Requesters that hold valid/data/last until accepted.
    task automatic agent_cycle(input int pv, input int pl, input int pf,
                               input bit alt, input bit rrst, input bit [1:0] dmask);
        bit acc [2][3];
        logic [2:0] rdy;
        for (int d = 0; d < 2; d++) begin
            if (dmask[d]) begin
                for (int i = 0; i < ((d == 0) ? 2 : 3); i++) begin
                    if (!val[d][i] && int'($urandom_range(0, 99)) < pv) begin
                        val[d][i] = 1'b1;
                        dat[d][i] = {4'(i), 4'(seq[d][i])};
                        lst[d][i] = alt ? ((seq[d][i] % 2) == 1) : (int'($urandom_range(0, 99)) < pl);
                    end
                end
                full[d] = (int'($urandom_range(0, 99)) < pf);
            end
        end
        if (rrst) rst_n = ($urandom_range(0, 299) != 0);
        half_neg();
        for (int d = 0; d < 2; d++) begin
            rdy = (d == 0) ? {1'b0, if2.req_ready} : if3.req_ready;
            for (int i = 0; i < 3; i++) acc[d][i] = val[d][i] && rdy[i];
        end
        if (if2.wr_uart) wlog.push_back(if2.data_in);
        half_pos();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 3; i++) begin
                if (acc[d][i]) begin
                    val[d][i] = 1'b0;
                    seq[d][i]++;
                end
            end
        end
    endtask

    typedef struct {
        logic [1:0] v;
        logic [1:0] l;
        logic [7:0] d0;
        logic       f;
        logic       wr;
        logic [7:0] dout;
        logic [1:0] g;
        logic       busy;
        logic [1:0] rdy;
    } vec_t;

    vec_t tbl [14];
    logic [7:0] alt_exp [8];

    initial begin
        vectors = 0;
        errors  = 0;
        rst_n   = 1'b0;
        clear_inputs();
        reset_model();

        tbl[0]  = '{2'b01, 2'b00, 8'hA1, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 2'b00};
        tbl[1]  = '{2'b01, 2'b00, 8'hA1, 1'b0, 1'b1, 8'hA1, 2'b01, 1'b1, 2'b01};
        tbl[2]  = '{2'b01, 2'b00, 8'hA2, 1'b0, 1'b1, 8'hA2, 2'b01, 1'b1, 2'b01};
        tbl[3]  = '{2'b01, 2'b01, 8'hA3, 1'b0, 1'b1, 8'hA3, 2'b01, 1'b1, 2'b01};
        tbl[4]  = '{2'b00, 2'b00, 8'h00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 2'b00};
        tbl[5]  = '{2'b01, 2'b00, 8'h54, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 2'b00};
        tbl[6]  = '{2'b01, 2'b00, 8'h54, 1'b0, 1'b1, 8'h54, 2'b01, 1'b1, 2'b01};
        for (int i = 7; i < 12; i++)
            tbl[i] = '{2'b01, 2'b00, 8'h55, 1'b1, 1'b0, 8'h55, 2'b01, 1'b1, 2'b00};
        tbl[12] = '{2'b01, 2'b01, 8'h55, 1'b0, 1'b1, 8'h55, 2'b01, 1'b1, 2'b01};
        tbl[13] = '{2'b00, 2'b00, 8'h00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 2'b00};

        alt_exp = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h02, 8'h03, 8'h12, 8'h13};

        // reset values and the 3-byte / tx_full table
        do_reset();
        for (int i = 0; i < 14; i++) begin
            val[0]    = {1'b0, tbl[i].v};
            lst[0]    = {1'b0, tbl[i].l};
            dat[0][0] = tbl[i].d0;
            full[0]   = tbl[i].f;
            half_neg();
            chk($sformatf("tbl%0d_wr", i),    32'(if2.wr_uart),   32'(tbl[i].wr));
            chk($sformatf("tbl%0d_data", i),  32'(if2.data_in),   32'(tbl[i].dout));
            chk($sformatf("tbl%0d_grant", i), 32'(if2.grant),     32'(tbl[i].g));
            chk($sformatf("tbl%0d_busy", i),  32'(if2.busy),      32'(tbl[i].busy));
            chk($sformatf("tbl%0d_ready", i), 32'(if2.req_ready), 32'(tbl[i].rdy));
            half_pos();
        end

        // both requesters continuously valid, 2-byte messages
        do_reset();
        wlog.delete();
        for (int c = 0; c < 12; c++) agent_cycle(100, 0, 0, 1'b1, 1'b0, 2'b01);
        chk("alt_count_ge8", 32'(wlog.size() >= 8), 32'd1);
        for (int k = 0; k < 8 && k < wlog.size(); k++)
            chk($sformatf("alt_byte%0d", k), 32'(wlog[k]), 32'(alt_exp[k]));

        // watchdog: req0 stalls after one byte while req1 waits
        do_reset();
        val[0] = 3'b011; lst[0] = 3'b010;
        dat[0][0] = 8'hB0; dat[0][1] = 8'hC0;
        step();
        half_neg();
        chk("wd_grant0", 32'(if2.grant), 32'h1);
        chk("wd_wr_b0", 32'(if2.wr_uart), 32'h1);
        half_pos();
        val[0] = 3'b010;
        for (int k = 1; k <= TMO; k++) begin
            half_neg();
            chk($sformatf("wd_abort_k%0d", k), 32'(if2.abort), 32'(k == TMO));
            chk($sformatf("wd_wr_k%0d", k), 32'(if2.wr_uart), 32'h0);
            half_pos();
        end
        half_neg();
        chk("wd_idle_busy", 32'(if2.busy), 32'h0);
        half_pos();
        half_neg();
        chk("wd_grant1", 32'(if2.grant), 32'h2);
        chk("wd_data_c0", 32'(if2.data_in), 32'hC0);
        half_pos();
        val[0] = 3'b000;
        step();

        // single-byte message, then reset in the middle of a 4-byte message
        do_reset();
        val[0] = 3'b001; lst[0] = 3'b001; dat[0][0] = 8'h31;
        step();
        half_neg();
        chk("sb_wr", 32'(if2.wr_uart), 32'h1);
        half_pos();
        val[0] = 3'b000;
        half_neg();
        chk("sb_busy_drop", 32'(if2.busy), 32'h0);
        half_pos();
        val[0] = 3'b001; lst[0] = 3'b000; dat[0][0] = 8'h41;
        step();
        half_neg();
        chk("mr_byte1", 32'(if2.data_in), 32'h41);
        half_pos();
        dat[0][0] = 8'h42;
        rst_n = 1'b0;
        half_neg();
        chk("mr_no_wr_in_reset", 32'(if2.wr_uart), 32'h0);
        half_pos();
        rst_n = 1'b1;
        val[0] = 3'b011; lst[0] = 3'b010; dat[0][1] = 8'h51;
        half_neg();
        chk("mr_grant_rst", 32'(if2.grant), 32'h0);
        chk("mr_busy_rst", 32'(if2.busy), 32'h0);
        chk("mr_wr_rst", 32'(if2.wr_uart), 32'h0);
        chk("mr_data_rst", 32'(if2.data_in), 32'h0);
        half_pos();
        half_neg();
        chk("mr_grant_req0", 32'(if2.grant), 32'h1);
        half_pos();

        // NREQ=3 pointer wrap from req2 to req0
        do_reset();
        val[1] = 3'b100; lst[1] = 3'b100; dat[1][2] = 8'h72;
        step();
        half_neg();
        chk("n3_grant2", 32'(if3.grant), 32'h4);
        chk("n3_wr2", 32'(if3.wr_uart), 32'h1);
        half_pos();
        val[1] = 3'b011; lst[1] = 3'b011; dat[1][0] = 8'h70; dat[1][1] = 8'h71;
        half_neg();
        chk("n3_idle", 32'(if3.grant), 32'h0);
        half_pos();
        half_neg();
        chk("n3_grant0", 32'(if3.grant), 32'h1);
        chk("n3_data0", 32'(if3.data_in), 32'h70);
        half_pos();

        // randomized traffic on both arbiters against the model
        do_reset();
        for (int c = 0; c < 3000; c++) agent_cycle(30, 40, 20, 1'b0, 1'b1, 2'b11);
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin message arbiter that shares the single UART transmit path between several byte-stream requesters. It grants one requester at a time and holds the grant for a whole message, up to and including the byte flagged `last`. It forwards bytes into the UART TX FIFO write port under `tx_full` backpressure. A watchdog reclaims the grant from a requester that stalls mid-message.

## Interface
Parameters:
- `NREQ`, 2: number of requesters, 2..8.
- `DBIT`, 8: data bits per byte.
- `TMO`, 1024: idle cycles tolerated mid-message before abort, ≥2.
- `TMO_W`, 11: watchdog counter width, must satisfy 2^TMO_W > TMO.

Ports:
- `clk` input 1: single clock; all logic rising-edge.
- `reset` input 1: synchronous, active-low reset.
- `req_valid` input NREQ: requester i presents a byte.
- `req_data` input NREQ*DBIT: byte of requester i at bits [i*DBIT +: DBIT].
- `req_last` input NREQ: byte of requester i ends its message.
- `req_ready` output NREQ: byte of requester i accepted this cycle when valid&ready.
- `tx_full` input 1: UART TX FIFO full.
- `wr_uart` output 1: UART TX FIFO write strobe.
- `data_in` output DBIT: byte to UART TX FIFO.
- `grant` output NREQ: one-hot current owner, registered.
- `busy` output 1: a message is in progress.
- `abort` output 1: one-cycle pulse when the watchdog revokes a grant.

## Operation
- The FSM has two states.
- IDLE:
  - `grant`=0, `busy`=0, all `req_ready`=0.
  - If any `req_valid` is high, pick the first valid index at or after `rr_ptr`, searching upward with modulo-NREQ wrap.
  - Register the one-hot `grant` and move to XFER.
  - With no valid request, stay in IDLE.
- XFER:
  - Owner g: `req_ready[g]` = ~`tx_full`; every other `req_ready` = 0.
  - `wr_uart` = `req_valid[g]` & ~`tx_full`, combinational.
  - `data_in` = `req_data[g]`; it is muxed whenever in XFER and is 0 in IDLE.
  - On a handshake with `req_last[g]`=1: go to IDLE, clear `grant`, set `rr_ptr` = (g+1) mod NREQ.
- Watchdog:
  - `tmo_cnt` counts every XFER cycle without a handshake, whatever the cause (`req_valid` low or `tx_full` high).
  - `tmo_cnt` clears on each handshake and on entry to XFER.
  - When `tmo_cnt` reaches TMO-1 with no handshake in that cycle: pulse `abort`, go to IDLE, set `rr_ptr` = (g+1) mod NREQ.
  - The remainder of the aborted message is not forwarded. Any later bytes from that requester start a new message.
- Non-owner requesters are never dropped; they wait with `req_valid` held.
- Requesters must hold data, last and valid stable until ready.

## Timing
- Reset values (reset=0 at a clock edge):
  - State = IDLE, `rr_ptr`=0, `tmo_cnt`=0.
  - `grant`=0, `busy`=0, `abort`=0, `req_ready`=0, `wr_uart`=0, `data_in`=0.
- Reset mid-message: the same reset values apply. No write occurs in the reset cycle, and the partial message is abandoned.
- Arbitration latency: request seen in IDLE at cycle n; `grant` and `busy` high at n+1. The first byte can be accepted at n+1.
- Throughput: 1 byte/cycle while `tx_full`=0.
- Message turnaround: after the last-byte handshake at cycle m, IDLE at m+1; the next grant is visible at m+2.
- `tx_full` rising in the same cycle as `req_valid`: no write and no handshake; the byte is retried.
- Single-byte message (valid&last on the first XFER cycle): XFER lasts exactly 1 cycle.
- The `abort` and last-handshake conditions are mutually exclusive; the handshake wins because it clears the counter.
- NREQ not a power of two: the `rr_ptr` wrap uses an explicit compare to NREQ-1, not overflow.

## Structure
- Package `uart_arb_pkg`: state encodings `ST_IDLE`/`ST_XFER`, helper function for ceil-log2 of NREQ (`rr_ptr` width).
- Sub-module `rr_pick`: combinational round-robin selector. Inputs are the request vector and the pointer; outputs are the one-hot grant and the binary index.
- The top level holds the FSM, `rr_ptr`, watchdog and output muxes.

## Test plan
- Reset then NREQ=2, req0 sends 3 bytes 0xA1,0xA2,0xA3(last) with `tx_full`=0:
  - `grant`=01 one cycle after request.
  - `wr_uart` high 3 consecutive cycles, `data_in` A1,A2,A3.
  - `busy` drops the cycle after A3.
- Both requesters valid continuously, each sending 2-byte messages:
  - Grants alternate 01,10,01,10 starting at req0.
  - No byte interleaving between messages.
- `tx_full` asserted for 5 cycles mid-message on byte 0x55:
  - `wr_uart`=0 and `req_ready`=0 during the 5 cycles.
  - 0x55 written once on the first cycle `tx_full`=0.
- With TMO=8, the owner drops valid after byte 1:
  - `abort` pulses after 8 stalled cycles.
  - Grant passes to the waiting req1.
  - `rr_ptr` points past req0.
- `reset` low during the 2nd of 4 bytes:
  - Next cycle all outputs are at reset values.
  - No further write; after reset release, req0 (pointer 0) is granted first.
- NREQ=3, only req2 valid, then only req0:
  - req2 is granted, then `rr_ptr` wraps to 0 and req0 is granted.
